// File: rtl/waveform_ctl.sv
// waveform_ctl: streams a channel's colour RAM out as a WS281x-style NRZ waveform.
// Each pixel bit is a timed high phase followed by a timed low phase, MSB first,
// and the frame ends with a low reset code followed by a one-cycle done pulse.
// Build option: define WAVEFORM_CTL_RGBW_EN for 32-bit RGBW pixels; otherwise
// pixels are 24-bit and RAM bits [31:24] are ignored.
module waveform_ctl #(
    parameter int RST_CYCLES = 5000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  reg_t0h_i,
    input  logic [7:0]  reg_t0l_i,
    input  logic [7:0]  reg_t1h_i,
    input  logic [7:0]  reg_t1l_i,
    input  logic [7:0]  reg_chan_len_i,
    output logic        ram_rd_en_o,
    output logic [7:0]  ram_rd_addr_o,
    input  logic [31:0] ram_rd_data_i,
    output logic        bit_o,
    output logic        busy_o,
    output logic        done_o
);

`ifdef WAVEFORM_CTL_RGBW_EN
    localparam int PIX_BITS = 32;
`else
    localparam int PIX_BITS = 24;
    logic unused_rd_hi;
    assign unused_rd_hi = ^ram_rd_data_i[31:24];
`endif
    localparam int RW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_RESET
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            t0h_q, t0h_d, t0l_q, t0l_d, t1h_q, t1h_d, t1l_q, t1l_d;
    logic [7:0]            len_q, len_d;
    logic [8:0]            pix_cnt_q, pix_cnt_d;
    logic [7:0]            addr_q, addr_d;
    logic [PIX_BITS-1:0]   shift_q, shift_d;
    logic [PIX_BITS-1:0]   pre_q, pre_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            phase_q, phase_d;
    logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
    logic                  rd_en_q, rd_en_d;
    logic                  pf_cap_q, pf_cap_d;
    logic                  done_q, done_d;

    logic                  enter_high;
    logic                  hi_bit;
    logic [PIX_BITS-1:0]   next_word;
    logic [PIX_BITS-1:0]   pix_word;

    assign next_word = ram_rd_data_i[PIX_BITS-1:0];

    function automatic logic [7:0] nz(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    // Sequencer: frame state, bit/pixel/phase counters, prefetch and RAM strobe
    always_comb begin
        state_d    = state_q;
        t0h_d      = t0h_q;
        t0l_d      = t0l_q;
        t1h_d      = t1h_q;
        t1l_d      = t1l_q;
        len_d      = len_q;
        pix_cnt_d  = pix_cnt_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        pre_d      = pre_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        rst_cnt_d  = rst_cnt_q;
        rd_en_d    = 1'b0;
        pf_cap_d   = rd_en_q && (state_q == S_HIGH);
        done_d     = 1'b0;
        enter_high = 1'b0;
        hi_bit     = 1'b0;
        pix_word   = pf_cap_q ? next_word : pre_q;

        // Prefetched word arrives the cycle after its strobe.
        if (pf_cap_q) begin
            pre_d = next_word;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    t0h_d     = nz(reg_t0h_i);
                    t0l_d     = nz(reg_t0l_i);
                    t1h_d     = nz(reg_t1h_i);
                    t1l_d     = nz(reg_t1l_i);
                    len_d     = reg_chan_len_i;
                    pix_cnt_d = '0;
                    addr_d    = '0;
                    rd_en_d   = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d    = next_word;
                bit_cnt_d  = 5'(PIX_BITS - 1);
                enter_high = 1'b1;
                hi_bit     = next_word[PIX_BITS-1];
                state_d    = S_HIGH;
            end
            S_HIGH: begin
                if (phase_q == 8'd1) begin
                    phase_d = shift_q[PIX_BITS-1] ? t1l_q : t0l_q;
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_LOW: begin
                if (phase_q != 8'd1) begin
                    phase_d = phase_q - 8'd1;
                end else if (bit_cnt_q != 5'd0) begin
                    shift_d    = shift_q << 1;
                    bit_cnt_d  = bit_cnt_q - 5'd1;
                    enter_high = 1'b1;
                    hi_bit     = shift_q[PIX_BITS-2];
                    state_d    = S_HIGH;
                end else if (pix_cnt_q != {1'b0, len_q}) begin
                    // When the prefetch capture lands on this very edge, take
                    // the word straight from the RAM bus.
                    shift_d    = pix_word;
                    bit_cnt_d  = 5'(PIX_BITS - 1);
                    pix_cnt_d  = pix_cnt_q + 9'd1;
                    enter_high = 1'b1;
                    hi_bit     = pix_word[PIX_BITS-1];
                    state_d    = S_HIGH;
                end else begin
                    rst_cnt_d = RW'(RST_CYCLES);
                    state_d   = S_RESET;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RW'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q - RW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_high) begin
            phase_d = hi_bit ? t1h_q : t0h_q;
            if ((bit_cnt_d == 5'd0) && (pix_cnt_d != {1'b0, len_q})) begin
                rd_en_d = 1'b1;
                addr_d  = addr_q + 8'd1;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            t0h_q     <= '0;
            t0l_q     <= '0;
            t1h_q     <= '0;
            t1l_q     <= '0;
            len_q     <= '0;
            pix_cnt_q <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            pre_q     <= '0;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            rst_cnt_q <= '0;
            rd_en_q   <= 1'b0;
            pf_cap_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            t0h_q     <= t0h_d;
            t0l_q     <= t0l_d;
            t1h_q     <= t1h_d;
            t1l_q     <= t1l_d;
            len_q     <= len_d;
            pix_cnt_q <= pix_cnt_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            pre_q     <= pre_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            rst_cnt_q <= rst_cnt_d;
            rd_en_q   <= rd_en_d;
            pf_cap_q  <= pf_cap_d;
            done_q    <= done_d;
        end
    end

    assign bit_o         = (state_q == S_HIGH);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign ram_rd_en_o   = rd_en_q;
    assign ram_rd_addr_o = addr_q;

endmodule

// File: doc/waveform_ctl.md
# waveform_ctl

Serialises one channel's pixel words from its colour RAM into a WS281x-style NRZ waveform. Sits directly downstream of `channel_ctl`. On the RAM-write-done pulse it reads `reg_chan_len_i + 1` pixel words and drives each bit MSB-first as a timed high phase followed by a timed low phase. The frame ends with a low reset code. Bit timings come from the four timing registers, counted in clock cycles.

## Interface
- `RST_CYCLES`, default 5000: length of the trailing low reset code, in clk cycles; minimum 1.
- `clk_i` input 1: clock; all logic on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: one-cycle frame start, driven by `channel_ctl`'s `ram_wr_done_o`.
- `reg_t0h_i`, `reg_t0l_i`, `reg_t1h_i`, `reg_t1l_i` input 8 each: phase lengths in cycles; 0 is treated as 1.
- `reg_chan_len_i` input 8: pixel count minus 1.
- `ram_rd_en_o` output 1: RAM read strobe.
- `ram_rd_addr_o` output 8: pixel word address.
- `ram_rd_data_i` input 32: RAM read data, valid exactly 1 cycle after `ram_rd_en_o`.
- `bit_o` output 1: serial LED data.
- `busy_o` output 1: frame in progress.
- `done_o` output 1: one-cycle pulse when the reset code completes.

## Operation
- **States:** IDLE, FETCH, LOAD, HIGH, LOW, RESET.
- **Reset values:** `bit_o`, `busy_o`, `done_o` and `ram_rd_en_o` are 0; `ram_rd_addr_o` is 0. State is IDLE.
- **IDLE:**
  - On `start_i`, latch the four timing registers (0→1) and `reg_chan_len_i`.
  - Clear the pixel counter and set the address to 0.
  - Go to FETCH.
  - `start_i` is ignored in every other state.
- **FETCH:** assert `ram_rd_en_o` for 1 cycle, then go to LOAD.
- **LOAD:**
  - Capture `ram_rd_data_i` into the shift register.
  - Set the bit counter to PIX_BITS−1.
  - Go to HIGH.
- **HIGH:**
  - `bit_o` = 1 for T1H cycles if the shift MSB is 1, otherwise T0H cycles.
  - Then go to LOW.
- **LOW:**
  - `bit_o` = 0 for T1L or T0L cycles, selected by the same bit.
  - At the end, if bits remain: shift left, decrement the bit counter, go to HIGH.
  - If the pixel is done and pixels remain: load the prefetched word, go to HIGH (no gap).
  - If it was the last pixel: go to RESET.
- **Prefetch:**
  - On entry to HIGH for the last bit of a pixel that is not the last, pulse `ram_rd_en_o` with address +1.
  - Capture the data into the prefetch register on the following cycle.
- **RESET:**
  - `bit_o` = 0 for RST_CYCLES cycles.
  - Then pulse `done_o` for 1 cycle and return to IDLE.
- **Arithmetic:**
  - Pixel counter is 9 bits, so `reg_chan_len_i` = 255 gives 256 pixels; the address wraps 255→0 only after the frame.
  - Phase counter is 8 bits and counts down to 1.
- **Register changes:** changing any `reg_*` input mid-frame has no effect on the frame in progress.
- **Reset mid-frame:** `rst_i` aborts immediately. All outputs return to reset values on the next edge, with no `done_o`.

## Timing
- `start_i` at edge N:
  - `busy_o` = 1 and FETCH from N+1, with `ram_rd_en_o` = 1 in N+1.
  - LOAD in N+2.
  - First `bit_o` high in N+3.
- Bit period = high + low cycles exactly, with no inter-bit or inter-pixel idle cycles.
- `busy_o` falls in the same cycle `done_o` pulses.
- `ram_rd_en_o` is never high for 2 consecutive cycles.

## Configuration
- `WAVEFORM_CTL_RGBW_EN`:
  - Defined: PIX_BITS = 32; the pixel is `ram_rd_data_i[31:0]`, sent MSB first (G, R, B, W).
  - Undefined: PIX_BITS = 24; the pixel is `ram_rd_data_i[23:0]` and bits [31:24] are ignored.

## Test plan
- **Single pixel:** T0H=1, T0L=2, T1H=3, T1L=4, len=0, word 0x00800001 (24-bit).
  - `bit_o` = 3 high / 4 low once, then 22× (1 high / 2 low), then 3 high / 4 low.
  - Then RST_CYCLES low, then one `done_o` pulse.
  - Total busy = 2 + 7 + 66 + 7 + RST_CYCLES cycles.
- **Back-to-back pixels:** len=2, words 0xFFFFFF, 0x000000, 0xAAAAAA.
  - Addresses read are 0, 1, 2, each exactly once.
  - No gap cycle at pixel boundaries; `done_o` fires once.
- **Zero timing:** all timing registers = 0 → every phase lasts 1 cycle and the bit period is 2.
- **Start while busy, plus register change:** assert `start_i` mid-frame and change `reg_t1h_i` mid-frame.
  - Frame length is unchanged and there is no restart.
  - `done_o` fires once.
- **Reset mid-frame:** `rst_i` during the HIGH of pixel 1.
  - `bit_o`, `busy_o` and `ram_rd_en_o` are 0 on the next edge; no `done_o`.
  - A following `start_i` reads from address 0.
- **RGBW build:** with `WAVEFORM_CTL_RGBW_EN`, word 0x01000000 and len=0.
  - First 7 bits are 0-codes, the 8th is a 1-code.
  - 32 bits total precede RESET.
